// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
// Channel count and select width are fixed to the mux being scanned.
package mux_scan_pkg;

    localparam int unsigned MUX_NUM_CH = 4;
    localparam int unsigned MUX_SEL_W  = 2;
    localparam int unsigned MUX_CNT_W  = 8;

    localparam logic [MUX_SEL_W-1:0] MUX_LAST_CH = MUX_SEL_W'(MUX_NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Terminal count of the dwell counter for a given dwell length.
    function automatic logic [MUX_CNT_W-1:0] dwell_last_cnt(input int unsigned dwell);
        return MUX_CNT_W'(dwell - 1);
    endfunction

endpackage

// File: rtl/mux_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled, clear has priority.
// last flags the final clock of a dwell period.
module mux_dwell_timer
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam logic [MUX_CNT_W-1:0] LAST_CNT = dwell_last_cnt(DWELL);

    logic [MUX_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + MUX_CNT_W'(1);
        end
    end

    assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps s through every channel, samples y, compares to exp.
// Define MUX_SCAN_CONT_EN for back-to-back scans while start stays high.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  y,
    input  logic [MUX_NUM_CH-1:0] exp,
    output logic [MUX_SEL_W-1:0]  s,
    output logic                  busy,
    output logic                  done,
    output logic [MUX_NUM_CH-1:0] result,
    output logic                  match
);

    state_t                state;
    logic                  armed;
    logic [MUX_NUM_CH-1:0] scratch;
    logic                  dwell_last;
    logic                  timer_clr_c;
    logic                  timer_en_c;
    logic [MUX_NUM_CH-1:0] scan_word_c;

    // Counter idles at zero outside SCAN and restarts at the end of every dwell.
    assign timer_en_c  = (state == ST_SCAN);
    assign timer_clr_c = (state != ST_SCAN) || dwell_last;

    mux_dwell_timer #(
        .DWELL (DWELL)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr_c),
        .en    (timer_en_c),
        .last  (dwell_last)
    );

    // Scratch with the sample currently being taken merged in, so the final
    // channel lands in result on the same edge it is captured.
    always_comb begin
        scan_word_c    = scratch;
        scan_word_c[s] = y;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            s       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            match   <= 1'b0;
            scratch <= '0;
            armed   <= 1'b1;
        end else begin
            done <= 1'b0;
            if (!start) begin
                armed <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start && armed) begin
                        state <= ST_SCAN;
                        s     <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (dwell_last) begin
                        scratch <= scan_word_c;
                        if (s == MUX_LAST_CH) begin
                            state  <= ST_DONE;
                            s      <= '0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            result <= scan_word_c;
                            match  <= (scan_word_c == exp);
`ifdef MUX_SCAN_CONT_EN
                            armed  <= 1'b1;
`else
                            armed  <= 1'b0;
`endif
                        end else begin
                            s <= s + MUX_SEL_W'(1);
                        end
                    end
                end
                ST_DONE: begin
`ifdef MUX_SCAN_CONT_EN
                    if (start) begin
                        state <= ST_SCAN;
                        s     <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a behavioural 4:1 mux in the feedback path.
// One instance at DWELL=4, a second at DWELL=1.
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst_n;

    logic       start;
    logic [3:0] t;
    logic [3:0] exp_w;
    logic       y;
    logic [1:0] s;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       match;

    logic       start1;
    logic [3:0] t1;
    logic [3:0] exp1;
    logic       y1;
    logic [1:0] s1;
    logic       busy1;
    logic       done1;
    logic [3:0] result1;
    logic       match1;

    int checks = 0;
    int errors = 0;
    int pulses;

    assign y  = t[s];
    assign y1 = t1[s1];

    mux_scan_ctrl #(.DWELL(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .y      (y),
        .exp    (exp_w),
        .s      (s),
        .busy   (busy),
        .done   (done),
        .result (result),
        .match  (match)
    );

    mux_scan_ctrl #(.DWELL(1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start1),
        .y      (y1),
        .exp    (exp1),
        .s      (s1),
        .busy   (busy1),
        .done   (done1),
        .result (result1),
        .match  (match1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Pulse start for one edge, then walk the 16 scan cycles checking s.
    task automatic scan_and_check_s(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy0"}, 32'(busy), 32'd1);
        for (int m = 0; m < 16; m++) begin
            check({tag, "_s"}, 32'(s), 32'(m / 4));
            check({tag, "_nodone"}, 32'(done), 32'd0);
            step();
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        t      = 4'b0000;
        exp_w  = 4'b0000;
        start1 = 1'b0;
        t1     = 4'b0000;
        exp1   = 4'b0000;

        // 1: reset
        step();
        step();
        check("rst_s", 32'(s), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_match", 32'(match), 32'd0);
        rst_n = 1'b1;
        step();

        // 2: matching scan, done 16 edges after start
        t     = 4'b1001;
        exp_w = 4'b1001;
        scan_and_check_s("scan2");
        check("scan2_done", 32'(done), 32'd1);
        check("scan2_result", 32'(result), 32'h9);
        check("scan2_match", 32'(match), 32'd1);
        check("scan2_busy", 32'(busy), 32'd0);
        check("scan2_s_wrap", 32'(s), 32'd0);
        step();
        check("scan2_done_pulse", 32'(done), 32'd0);
        check("scan2_hold", 32'(result), 32'h9);
        step();

        // 3: mismatch then match
        t     = 4'b0100;
        exp_w = 4'b1101;
        scan_and_check_s("scan3a");
        check("scan3a_done", 32'(done), 32'd1);
        check("scan3a_result", 32'(result), 32'h4);
        check("scan3a_match", 32'(match), 32'd0);
        step();
        t = 4'b1101;
        scan_and_check_s("scan3b");
        check("scan3b_done", 32'(done), 32'd1);
        check("scan3b_result", 32'(result), 32'hd);
        check("scan3b_match", 32'(match), 32'd1);
        step();

        // 4: held start gives exactly one scan
        t     = 4'b0110;
        exp_w = 4'b0000;
        start = 1'b1;
        step();
        repeat (16) step();
        check("held_done", 32'(done), 32'd1);
        check("held_result", 32'(result), 32'h6);
        check("held_match", 32'(match), 32'd0);
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (done || busy) pulses++;
        end
        check("held_no_rescan", 32'(pulses), 32'd0);
        start = 1'b0;
        step();
        t     = 4'b1010;
        start = 1'b1;
        step();
        check("rearm_busy", 32'(busy), 32'd1);
        start = 1'b0;
        repeat (16) step();
        check("rearm_done", 32'(done), 32'd1);
        check("rearm_result", 32'(result), 32'ha);
        step();

        // 5: reset while s=10 aborts the scan
        t     = 4'b0011;
        exp_w = 4'b0011;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        check("abort_s10", 32'(s), 32'd2);
        rst_n = 1'b0;
        step();
        step();
        check("abort_s", 32'(s), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_match", 32'(match), 32'd0);
        rst_n = 1'b1;
        step();
        scan_and_check_s("scan5");
        check("scan5_done", 32'(done), 32'd1);
        check("scan5_result", 32'(result), 32'h3);
        check("scan5_match", 32'(match), 32'd1);
        step();

        // 6: DWELL=1, start dropped at s=01
        t1     = 4'b1101;
        exp1   = 4'b1101;
        start1 = 1'b1;
        step();
        check("d1_s0", 32'(s1), 32'd0);
        check("d1_busy", 32'(busy1), 32'd1);
        step();
        check("d1_s1", 32'(s1), 32'd1);
        start1 = 1'b0;
        step();
        check("d1_s2", 32'(s1), 32'd2);
        step();
        check("d1_s3", 32'(s1), 32'd3);
        check("d1_nodone", 32'(done1), 32'd0);
        step();
        check("d1_done", 32'(done1), 32'd1);
        check("d1_result", 32'(result1), 32'hd);
        check("d1_match", 32'(match1), 32'd1);
        check("d1_busy_end", 32'(busy1), 32'd0);
        step();
        check("d1_done_pulse", 32'(done1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
